// File: rtl/jimmy_pkg.sv
// rtl/jimmy_pkg.sv - shared opcode constants, NOP encoding and loader state type
//
// Imported by progmem_load_fsm and program_memory_loader.
package jimmy_pkg;

    // High nibble of the NOP instruction; the low nibble is unused by NOP.
    localparam logic [3:0] OPC_NOP      = 4'h7;
    localparam logic [7:0] NOP_ENCODING = {OPC_NOP, 4'h0};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CHECK = 3'd3,
        ST_ERROR = 3'd4
    } load_state_e;

endpackage

// File: rtl/progmem_load_fsm.sv
// rtl/progmem_load_fsm.sv - load stream handshake and state machine
//
// Accepts a length word L followed by L+1 data words and issues one memory
// write per data word. With PROGMEM_CHECKSUM_EN defined, one extra checksum
// word follows and the modular sum of all words must be zero.
//
// Ports:
//   clk_i, reset_i           clock, synchronous active-low reset
//   load_start_i             request to begin a load (IDLE / ERROR only)
//   in_data_i/valid_i/ready_o  load stream handshake
//   cpu_hold_o               high whenever the loader is not IDLE
//   load_done_o              one-cycle pulse in the first IDLE cycle after success
//   load_error_o             sticky checksum failure (tied low without the macro)
//   wr_en_o/addr_o/data_o    write port into the program memory
module progmem_load_fsm #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_start_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              cpu_hold_o,
    output logic              load_done_o,
    output logic              load_error_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o
);
    import jimmy_pkg::*;

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    // Words still to be written; one bit wider so a full-depth load fits.
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              xfer;
`ifdef PROGMEM_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              err_q, err_d;
`endif

    assign in_ready_o = (state_q == ST_LEN) || (state_q == ST_LOAD) ||
                        (state_q == ST_CHECK);
    assign xfer       = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
`ifdef PROGMEM_CHECKSUM_EN
            sum_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            done_q  <= done_d;
`ifdef PROGMEM_CHECKSUM_EN
            sum_q   <= sum_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        done_d  = 1'b0;
        wr_en_o = 1'b0;
`ifdef PROGMEM_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load_start_i) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    count_d = {1'b0, in_data_i[ADDR_W-1:0]} + CNT_ONE;
                    ptr_d   = '0;
`ifdef PROGMEM_CHECKSUM_EN
                    sum_d   = in_data_i;
`endif
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    wr_en_o = 1'b1;
                    count_d = count_q - CNT_ONE;
`ifdef PROGMEM_CHECKSUM_EN
                    sum_d   = sum_q + in_data_i;
`endif
                    if (count_q == CNT_ONE) begin
`ifdef PROGMEM_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        // Only advanced between words, so a full-depth load never wraps.
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
`ifdef PROGMEM_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer) begin
                    if ((sum_q + in_data_i) == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                if (load_start_i) begin
                    state_d = ST_LEN;
                    err_d   = 1'b0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign cpu_hold_o   = (state_q != ST_IDLE);
    assign load_done_o  = done_q;
    assign wr_addr_o    = ptr_q;
    assign wr_data_o    = in_data_i;
`ifdef PROGMEM_CHECKSUM_EN
    assign load_error_o = err_q;
`else
    assign load_error_o = 1'b0;
`endif

endmodule

// File: rtl/program_memory_loader.sv
// rtl/program_memory_loader.sv - CPU program memory with streaming loader
//
// Storage array plus combinational fetch port; the load protocol lives in
// progmem_load_fsm. Optional checksum checking: define PROGMEM_CHECKSUM_EN.
//
// Ports:
//   clk, reset               clock, synchronous active-low reset (fills NOP_WORD)
//   address_bus, data_bus    CPU fetch, data_bus = mem[address_bus] at all times
//   load_start               request to begin a load
//   in_data/in_valid/in_ready  load stream
//   cpu_hold                 CPU stall while a load is in progress or failed
//   load_done, load_error    success pulse, sticky checksum failure
module program_memory_loader
    import jimmy_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_ENCODING)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address_bus,
    output logic [DATA_W-1:0] data_bus,
    input  logic              load_start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    progmem_load_fsm #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_load_fsm (
        .clk_i        (clk),
        .reset_i      (reset),
        .load_start_i (load_start),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .cpu_hold_o   (cpu_hold),
        .load_done_o  (load_done),
        .load_error_o (load_error),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data)
    );

    // Reset refills every word so an aborted load leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= NOP_WORD;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign data_bus = mem_q[address_bus];

endmodule

// File: doc/program_memory_loader.md
PROGRAM_MEMORY_LOADER -- requirements
Module: program_memory_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 8: instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 8: address width; depth = 2**ADDR_W; ADDR_W <= DATA_W.
REQ-003 SHALL have parameter NOP_WORD, default 8'b0111_0000 zero-extended to DATA_W: fill word (NOP).
REQ-004 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port: reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port: address_bus  input  ADDR_W  CPU fetch address.
REQ-007 SHALL have port: data_bus  output  DATA_W  CPU fetch data.
REQ-008 SHALL have port: load_start  input  1  one-cycle request to begin a load.
REQ-009 SHALL have port: in_data  input  DATA_W  load stream word.
REQ-010 SHALL have port: in_valid  input  1  in_data valid.
REQ-011 SHALL have port: in_ready  output  1  block accepts in_data this cycle.
REQ-012 SHALL have port: cpu_hold  output  1  CPU must stall while high.
REQ-013 SHALL have port: load_done  output  1  one-cycle pulse on successful load.
REQ-014 SHALL have port: load_error  output  1  sticky checksum failure flag.

Function
REQ-015 SHALL drive data_bus = mem[address_bus] combinationally at all times, including during a load.
REQ-016 SHALL implement states IDLE, LEN, LOAD, CHECK, ERROR.
REQ-017 SHALL transfer a word only on a cycle where in_valid and in_ready are both 1.
REQ-018 SHALL hold in_ready = 0 in IDLE and ERROR, and 1 in LEN, LOAD, CHECK.
REQ-019 IDLE: load_start = 1 -> LEN next cycle; cpu_hold = 1 from that cycle onward.
REQ-020 LEN: first transferred word's low ADDR_W bits = L; count = L+1 words (1..depth); write pointer = 0; -> LOAD.
REQ-021 LOAD: each transfer writes mem[ptr] on that clock edge, then ptr+1; after word L+1 -> CHECK (macro on) or IDLE (macro off).
REQ-022 Addresses beyond the last loaded word SHALL keep their prior contents.
REQ-023 On a successful finish, SHALL pulse load_done for exactly one cycle, coincident with the cycle after entering IDLE; cpu_hold = 0 in that same cycle.
REQ-024 SHALL ignore load_start in any state other than IDLE and ERROR.
REQ-025 ERROR: cpu_hold and load_error stay 1; load_start -> LEN, clearing load_error.
REQ-026 L = 2**ADDR_W-1 SHALL fill the whole memory; pointer SHALL NOT wrap within a load.

Reset
REQ-027 On a clock edge with reset = 0: state IDLE, every mem word = NOP_WORD, pointer 0, count 0, cpu_hold 0, in_ready 0, load_done 0, load_error 0.
REQ-028 Reset during any load state SHALL abort the load with the REQ-027 result; no partial contents survive.

Configuration
REQ-029 Macro PROGMEM_CHECKSUM_EN defined: SHALL accumulate a DATA_W-bit modular sum over the length word and all data words; CHECK takes one more word; total sum = 0 -> IDLE with load_done, else -> ERROR.
REQ-030 Macro undefined: SHALL omit CHECK and the accumulator; load_error SHALL be tied 0; ERROR is unreachable.

Structure
REQ-031 SHALL place opcode constants, the NOP encoding and the state enum in shared package jimmy_pkg.
REQ-032 SHALL place the handshake/state machine in sub-module progmem_load_fsm; the storage array and read mux stay in the top module.

Verification
REQ-033 Reset, no load: address_bus = 0x00, 0x1F, 0xFF -> data_bus = 0x70 each; cpu_hold = 0.
REQ-034 Macro off: load_start, stream 0x02, 0x98, 0x99, 0x04 -> mem[0..2] = 0x98, 0x99, 0x04; mem[3] = 0x70; one load_done pulse; cpu_hold low afterwards.
REQ-035 Macro on: stream 0x01, 0x10, 0x20, checksum 0xCF -> load_done = 1, load_error = 0; checksum 0x00 instead -> ERROR, load_error = 1, cpu_hold = 1.
REQ-036 Backpressure: in_valid toggled every other cycle during a 4-word load -> writes occur only on handshake cycles; contents identical to the unstalled run.
REQ-037 Reset asserted after 2 of 5 data words -> all addresses read 0x70, state IDLE, cpu_hold = 0; a second load_start mid-LOAD -> ignored.
REQ-038 Full-depth load, L = 0xFF -> all 256 words written; mem[0] is not overwritten after word 256.
